dmac_read: RTL and testbench
============================

Name: dmac_read

Overview:
- Read-side engine of the DMA controller and the AXI read-channel initiator.
- Takes one transfer descriptor (source address, len, size, burst) and issues a single AR burst.
- Accepts R beats into a small elastic FIFO and presents them to the write-side engine on a valid/ready stream.
- Signals completion, with an error summary, when the last beat has been accepted.

Parameters:
- FIFO_DEPTH, 4, entries in the read-data buffer; power of two, at least 2.
- ARID_VAL, 0, constant ID driven on m_arid.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  start request; accepted only while ready_o=1
- ready_o  out  1  engine idle, can accept a descriptor
- src_addr_i  in  `ADDR_WIDTH  source start address
- len_i  in  `LEN_BITS  AXI len (beats-1)
- size_i  in  `SIZE_BITS  AXI size
- burst_i  in  2  AXI burst type
- m_arid  out  `ID_BITS  read ID (=ARID_VAL)
- m_araddr  out  `ADDR_WIDTH  burst address
- m_arlen  out  `LEN_BITS  burst length
- m_arsize  out  `SIZE_BITS  beat size
- m_arburst  out  2  burst type
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rid  in  `ID_BITS  read ID (ignored beyond the error check)
- m_rdata  in  `DATA_WIDTH  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- data_o  out  `DATA_WIDTH  buffered beat to the write engine
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  write engine accepts the beat
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error for the current/last transfer; valid when done_o=1

Behaviour:
- Reset: state=IDLE, FIFO empty, beat counter=0, err flag=0.
  - Output values under reset: ready_o=1, m_arvalid=0, m_rready=0, data_valid_o=0, done_o=0, err_o=0, m_araddr/len/size/burst=0.
- FSM states: IDLE, AR, R, DONE.
  - IDLE: ready_o=1. On valid_i, register src_addr/len/size/burst, clear the beat counter and err, and go to AR.
  - AR: m_arvalid=1 with the registered fields held stable. On m_arvalid&&m_arready, go to R.
    - A reset taken in AR drops m_arvalid; this is accepted protocol risk, and the interconnect is reset together with this block.
  - R: m_rready = !fifo_full. Beat accept = m_rvalid&&m_rready. Each accept pushes m_rdata into the FIFO and increments the beat counter.
    - On an accepted beat with m_rlast=1, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE. ready_o reasserts the cycle after DONE.
- Error flag (sticky until the next start) is set when any of these occurs on an accepted beat:
  - m_rresp!=0;
  - m_rid!=ARID_VAL;
  - m_rlast=1 with beat counter != registered len;
  - beat counter == len without m_rlast.
- Latency: the first m_rdata accept becomes visible on data_o the next cycle (registered FIFO output, 1-cycle latency). There is no combinational path from m_rvalid to data_valid_o.
- FIFO behaviour:
  - data_valid_o = !fifo_empty. Pop on data_valid_o&&data_ready_i.
  - data_o holds stable while data_valid_o=1 and data_ready_i=0.
  - Simultaneous push and pop: allowed when not full; occupancy is unchanged.
  - When full, m_rready=0 even if a pop occurs the same cycle (no full bypass).
- The FIFO is not flushed at DONE. Remaining beats drain to the write engine while the FSM is idle.
  - A new start does not wait for the drain; the write engine consumes beats in order.
- Width rules:
  - Beat counter is `LEN_BITS wide. len=255 gives 256 beats, and the counter wraps to 0 only after the last beat.
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits (extra wrap bit distinguishes full from empty).
- Reset mid-operation: every state, the FIFO, the counter and err return to reset values on the next edge. Buffered data is discarded.
- valid_i outside IDLE is ignored.

Decomposition:
- Shared package / define.sv holds:
  - `ADDR_WIDTH, `DATA_WIDTH, `LEN_BITS, `SIZE_BITS, `ID_BITS;
  - AXI burst encodings (FIXED=0, INCR=1, WRAP=2);
  - response encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - the DMA engine state enum shared with the write engine.
- Sub-module dmac_fifo (synchronous FIFO with full/empty and registered read data), parameterised by width and depth. It is reusable later for write-path buffering.

Test Plan:
- Single beat: start with src=0x1000, len=0, size=2, burst=INCR, arready after 2 cycles, one R beat 0xDEADBEEF with rlast.
  -> AR carries 0x1000/0/2/1; data_o=0xDEADBEEF one cycle after the accept; done_o pulses; err_o=0.
- Four-beat burst, len=3, data 0x11..0x44, data_ready_i=1 throughout.
  -> four in-order pops; done_o pulses 1 cycle after the last accept; ready_o=1 the next cycle.
- Backpressure: len=7, data_ready_i=0, FIFO_DEPTH=4.
  -> m_rready drops after 4 accepts; after data_ready_i rises, all 8 beats arrive in order with none lost or duplicated.
- Error cases:
  - m_rresp=2 on beat 2 of len=3 -> err_o=1 at done_o;
  - early rlast on beat 1 of len=3 -> err_o=1 and done_o.
- Reset mid-transfer: assert rst_i in R after 2 of 4 beats.
  -> next cycle ready_o=1, m_rready=0, data_valid_o=0; a new len=0 transfer then completes cleanly.
- Back-to-back: second valid_i issued the cycle ready_o returns, first burst's data not yet drained.
  -> second AR issued; data_o stream is burst1 beats followed by burst2 beats.

Source files
------------

// File: rtl/dmac_read_pkg.sv
// Shared DMA definitions: AXI field widths, burst/response encodings,
// and the engine state enum used by both the read and write engines.
package dmac_read_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;
  localparam int ID_BITS    = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  // Any response other than OKAY counts as a transfer error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dmac_fifo.sv
// Synchronous FIFO with full/empty flags and a registered read-data port.
// The output register always holds the entry at the head, so data shows
// up one cycle after it is pushed into an empty FIFO and stays stable
// while nobody pops.
module dmac_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] rdata_reg;
  logic             do_push, do_pop;
  logic             head_bypass;

  // Extra wrap bit separates full (same index, different lap) from empty.
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = rdata_reg;

  // A push landing on the slot that becomes the head must be forwarded,
  // because the memory does not hold it yet.
  assign head_bypass = do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

  // Pointer advance.
  always_comb begin
    wr_ptr_next = do_push ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
    rd_ptr_next = do_pop  ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage array, no reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata_i;
    end
  end

  // Registered head read, fetched at the address the head will have next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_reg <= '0;
    end else if (head_bypass) begin
      rdata_reg <= wdata_i;
    end else begin
      rdata_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/dmac_read.sv
// DMA read engine: issues one AXI AR burst per descriptor, buffers the
// returned R beats and streams them to the write engine, then pulses
// done_o with a sticky error summary for the transfer.
module dmac_read
  import dmac_read_pkg::*;
#(
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ID_BITS-1:0] ARID_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [LEN_BITS-1:0]   len_i,
  input  logic [SIZE_BITS-1:0]  size_i,
  input  logic [1:0]            burst_i,
  output logic [ID_BITS-1:0]    m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_BITS-1:0]   m_arlen,
  output logic [SIZE_BITS-1:0]  m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_BITS-1:0]    m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  done_o,
  output logic                  err_o
);

  dma_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_BITS-1:0]   len_reg;
  logic [SIZE_BITS-1:0]  size_reg;
  logic [1:0]            burst_reg;
  logic [LEN_BITS-1:0]   beat_cnt_reg;
  logic                  err_reg;
  logic                  fifo_full, fifo_empty;
  logic                  start, r_accept, beat_err;

  assign start    = (state_reg == ST_IDLE) && valid_i;
  assign r_accept = m_rvalid && m_rready;

  // A beat is bad on an error response, a foreign ID, or when rlast
  // disagrees with the beat count implied by len.
  assign beat_err = resp_is_err(m_rresp) ||
                    (m_rid != ARID_VAL) ||
                    (m_rlast && (beat_cnt_reg != len_reg)) ||
                    (!m_rlast && (beat_cnt_reg == len_reg));

  assign m_arid    = ARID_VAL;
  assign m_araddr  = addr_reg;
  assign m_arlen   = len_reg;
  assign m_arsize  = size_reg;
  assign m_arburst = burst_reg;
  assign err_o     = err_reg;
  assign data_valid_o = !fifo_empty;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (valid_i) state_next = ST_AR;
      ST_AR:   if (m_arready) state_next = ST_R;
      ST_R:    if (r_accept && m_rlast) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; R is throttled only by buffer space.
  always_comb begin
    ready_o   = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    done_o    = 1'b0;
    case (state_reg)
      ST_IDLE: ready_o   = 1'b1;
      ST_AR:   m_arvalid = 1'b1;
      ST_R:    m_rready  = !fifo_full;
      ST_DONE: done_o    = 1'b1;
      default: ;
    endcase
  end

  // Descriptor capture, beat counting and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg     <= '0;
      len_reg      <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (start) begin
      addr_reg     <= src_addr_i;
      len_reg      <= len_i;
      size_reg     <= size_i;
      burst_reg    <= burst_i;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (r_accept) begin
      beat_cnt_reg <= beat_cnt_reg + LEN_BITS'(1);
      if (beat_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  dmac_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_accept),
    .wdata_i (m_rdata),
    .pop_i   (data_ready_i),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_dmac_read.sv
// Bench for dmac_read: a behavioural AXI read slave plus a randomly
// stalling consumer, checked against a queue of delivered beats.
module tb_dmac_read;
  import dmac_read_pkg::*;

  localparam int                 DEPTH = 4;
  localparam logic [ID_BITS-1:0] ARID  = 4'h5;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [ADDR_WIDTH-1:0] src_addr_i;
  logic [LEN_BITS-1:0]   len_i;
  logic [SIZE_BITS-1:0]  size_i;
  logic [1:0]            burst_i;
  logic [ID_BITS-1:0]    m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [LEN_BITS-1:0]   m_arlen;
  logic [SIZE_BITS-1:0]  m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ID_BITS-1:0]    m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  data_ready_i;
  logic                  done_o;
  logic                  err_o;

  int total = 0;
  int bad   = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  int rdy_mode  = 0;   // 0 never ready, 1 always ready, 2 random
  int hold_cnt  = 0;   // cycles of forced not-ready before rdy_mode applies
  int first_stall = -1;
  bit chk_vis   = 1'b0;

  dmac_read #(
    .FIFO_DEPTH (DEPTH),
    .ARID_VAL   (ARID)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .src_addr_i   (src_addr_i),
    .len_i        (len_i),
    .size_i       (size_i),
    .burst_i      (burst_i),
    .m_arid       (m_arid),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arsize     (m_arsize),
    .m_arburst    (m_arburst),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_rid        (m_rid),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_rlast      (m_rlast),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Consumer: picks its ready for the coming edge, then scores any pop.
  initial begin
    data_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_cnt > 0) begin
        hold_cnt--;
        data_ready_i = 1'b0;
      end else begin
        case (rdy_mode)
          0:       data_ready_i = 1'b0;
          1:       data_ready_i = 1'b1;
          default: data_ready_i = ($urandom_range(0, 3) != 0);
        endcase
      end
      if (data_valid_o && data_ready_i) begin
        chk("pop_avail", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("pop_data", data_o, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One descriptor end to end. kind: 0 clean, 1 bad resp at beat eb,
  // 2 bad id at beat eb, 3 rlast early at beat eb, 4 rlast one beat late.
  // rst_at >= 0 resets the engine just before that beat is offered.
  task automatic run_xfer(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int kind_in, input int eb_in,
                          input int gap_max, input int ar_dly, input bit fixed,
                          input logic [31:0] d0, input logic [31:0] dstep,
                          input int rst_at);
    int kind, eb, last_idx, w, n;
    logic exp_err;
    logic [DATA_WIDTH-1:0] last_data;
    kind = kind_in;
    if (kind == 3 && len == 0) kind = 0;
    if (kind == 4 && len == 255) kind = 0;
    last_idx = len;
    eb = eb_in;
    if (eb < 0) eb = (kind == 3) ? $urandom_range(0, len - 1) : $urandom_range(0, len);
    if (kind == 3) last_idx = eb;
    if (kind == 4) last_idx = len + 1;
    exp_err = (kind != 0);
    last_data = '0;

    w = 0;
    while (!ready_o && w < 200) begin tick; w++; end
    chk("ready_wait", ready_o, 1);
    valid_i    = 1'b1;
    src_addr_i = addr;
    len_i      = LEN_BITS'(len);
    size_i     = SIZE_BITS'(size);
    burst_i    = 2'(burst);
    tick;
    valid_i    = 1'b0;
    src_addr_i = $urandom;
    len_i      = LEN_BITS'($urandom);
    chk("arvalid", m_arvalid, 1);
    n = (ar_dly < 0) ? $urandom_range(0, 3) : ar_dly;
    repeat (n) begin
      chk("ar_hold", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
          {1'b1, ARID, addr, LEN_BITS'(len), SIZE_BITS'(size), 2'(burst)});
      tick;
    end
    m_arready = 1'b1;
    chk("ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
        {ARID, addr, LEN_BITS'(len), SIZE_BITS'(size), 2'(burst)});
    tick;
    m_arready = 1'b0;
    chk("arvalid_drop", m_arvalid, 0);

    for (int i = 0; i <= last_idx; i++) begin
      if (i == rst_at) begin
        hold_cnt = 1000;
        rst_i = 1'b1;
        tick;
        chk("mid_rst", {ready_o, m_rready, data_valid_o, done_o, m_arvalid, err_o}, 6'b100000);
        rst_i = 1'b0;
        exp_q.delete();
        hold_cnt = 0;
        return;
      end
      repeat ($urandom_range(0, gap_max)) tick;
      m_rvalid = 1'b1;
      m_rdata  = fixed ? d0 + 32'(i) * dstep : $urandom;
      m_rid    = (kind == 2 && i == eb) ? (ARID ^ 4'h1) : ARID;
      m_rresp  = (kind == 1 && i == eb) ? 2'($urandom_range(1, 3)) : 2'd0;
      m_rlast  = (i == last_idx);
      w = 0;
      while (!m_rready && w < 200) begin
        if (first_stall < 0) first_stall = i;
        tick;
        w++;
      end
      if (w >= 200) chk("rready_wait", m_rready, 1);
      exp_q.push_back(m_rdata);
      last_data = m_rdata;
      tick;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rresp  = 2'd0;
      m_rid    = ARID;
    end
    chk("done", done_o, 1);
    chk("err", err_o, exp_err);
    if (chk_vis) chk("vis", {data_valid_o, data_o}, {1'b1, last_data});
    tick;
    chk("done_1cyc", done_o, 0);
    chk("ready_back", ready_o, 1);
  endtask

  task automatic drain;
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 1000) begin tick; w++; end
    chk("drained", exp_q.size(), 0);
    tick;
    chk("empty_after", data_valid_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; src_addr_i = '0; len_i = '0; size_i = '0; burst_i = '0;
    m_arready = 1'b0; m_rid = ARID; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    repeat (3) tick;
    chk("rst_ctrl", {ready_o, m_arvalid, m_rready, data_valid_o, done_o, err_o}, 6'b100000);
    chk("rst_ar", {m_araddr, m_arlen, m_arsize, m_arburst}, '0);
    rst_i = 1'b0;
    tick;

    // Single beat, data visible one cycle after accept.
    rdy_mode = 0;
    chk_vis = 1'b1;
    run_xfer(32'h1000, 0, 2, 1, 0, 0, 0, 2, 1'b1, 32'hDEADBEEF, 32'h0, -1);
    chk_vis = 1'b0;
    rdy_mode = 1;
    drain();

    // Four beats, consumer always ready.
    run_xfer(32'h2000, 3, 2, 1, 0, 0, 1, -1, 1'b1, 32'h11, 32'h11, -1);
    drain();

    // Backpressure: full buffer must stop R after DEPTH accepts.
    hold_cnt = 40;
    first_stall = -1;
    run_xfer(32'h3000, 7, 2, 1, 0, 0, 0, 0, 1'b0, 32'h0, 32'h0, -1);
    chk("stall_idx", first_stall, DEPTH);
    drain();

    // Error cases.
    run_xfer(32'h4000, 3, 2, 1, 1, 2, 1, -1, 1'b0, 32'h0, 32'h0, -1);
    run_xfer(32'h4100, 3, 2, 1, 3, 1, 1, -1, 1'b0, 32'h0, 32'h0, -1);
    run_xfer(32'h4200, 3, 2, 1, 2, 0, 1, -1, 1'b0, 32'h0, 32'h0, -1);
    run_xfer(32'h4300, 2, 2, 1, 4, 0, 1, -1, 1'b0, 32'h0, 32'h0, -1);
    drain();

    // Reset after two of four beats, then a clean single beat.
    run_xfer(32'h5000, 3, 2, 1, 0, 0, 0, 1, 1'b0, 32'h0, 32'h0, 2);
    run_xfer(32'h5100, 0, 2, 1, 0, 0, 0, 1, 1'b0, 32'h0, 32'h0, -1);
    drain();

    // Back-to-back with the first burst still buffered.
    hold_cnt = 30;
    run_xfer(32'h6000, 3, 2, 1, 0, 0, 0, 0, 1'b1, 32'hA0, 32'h1, -1);
    run_xfer(32'h7000, 3, 2, 2, 0, 0, 0, 0, 1'b1, 32'hB0, 32'h1, -1);
    drain();

    // Long burst exercising counter wrap.
    rdy_mode = 2;
    run_xfer(32'h8000, 255, 3, 1, 0, 0, 0, -1, 1'b0, 32'h0, 32'h0, -1);
    drain();

    // Randomised descriptors, errors and consumer stalls.
    for (int t = 0; t < 25; t++) begin
      run_xfer($urandom, $urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, -1,
               2, -1, 1'b0, 32'h0, 32'h0, -1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
